// File: rtl/sel_debounce_if.sv
// sel_debounce_if: pushbutton input and debounced select/level/pulse outputs
interface sel_debounce_if;
  logic btn_i;
  logic sel_o;
  logic stable_o;
  logic press_o;
  modport master(output btn_i, input sel_o, stable_o, press_o);
  modport slave(input btn_i, output sel_o, stable_o, press_o);
endinterface

// File: rtl/sel_debounce.sv
// sel_debounce: synchronizes and debounces a pushbutton; each accepted press toggles the mux select
module sel_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic clk_i,
  input logic rst_i,
  sel_debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_s1, r_btn_s, r_sel, r_stable, r_press, w_accept;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_s1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_state <= RELEASED;
      r_cnt <= '0;
      r_sel <= 1'b0;
      r_stable <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1 <= bus.btn_i;
      r_btn_s <= r_s1;
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_sel <= r_sel ^ w_accept;
      r_stable <= (w_state_nxt == PRESSED) || (w_state_nxt == CHECK_RELEASE);
      r_press <= w_accept;
    end
  // a single-cycle qualification window skips the CHECK states entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_accept = 1'b0;
    case (r_state)
      RELEASED:
        if (r_btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = PRESSED;
            w_accept = 1'b1;
          end else begin
            w_state_nxt = CHECK_PRESS;
            w_cnt_nxt = CW'(1);
          end
        end
      CHECK_PRESS:
        if (!r_btn_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt = '0;
          w_accept = 1'b1;
        end else w_cnt_nxt = r_cnt + CW'(1);
      PRESSED:
        if (!r_btn_s) begin
          w_state_nxt = (DEBOUNCE_CYCLES == 1) ? RELEASED : CHECK_RELEASE;
          w_cnt_nxt = (DEBOUNCE_CYCLES == 1) ? '0 : CW'(1);
        end
      CHECK_RELEASE:
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt = '0;
        end else w_cnt_nxt = r_cnt + CW'(1);
    endcase
  end
  assign bus.sel_o = r_sel;
  assign bus.stable_o = r_stable;
  assign bus.press_o = r_press;
endmodule

// File: tb/tb_sel_debounce.sv
// tb_sel_debounce: directed vectors for sel_debounce with DEBOUNCE_CYCLES=4
module tb_sel_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  int press_cnt = 0;
  int dbl = 0;
  int p0;
  logic prev = 1'b0;
  sel_debounce_if bus();
  sel_debounce #(.DEBOUNCE_CYCLES(4)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.press_o) press_cnt <= press_cnt + 1;
    if (bus.press_o && prev) dbl <= dbl + 1;
    prev <= bus.press_o;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] outs;
    return {bus.sel_o, bus.stable_o, bus.press_o};
  endfunction
  initial begin
    bus.btn_i = 1'b0;
    repeat (3) tick;
    chk("reset_outs", 32'(outs()), 0);
    rst = 1'b0;
    tick;
    p0 = press_cnt;
    bus.btn_i = 1'b1;
    repeat (5) tick;
    chk("clean_pre", 32'(outs()), 0);
    tick;
    chk("clean_accept", 32'(outs()), 3'b111);
    tick;
    chk("clean_pulse_end", 32'(outs()), 3'b110);
    repeat (20) tick;
    chk("clean_one_pulse", press_cnt - p0, 1);
    #4 rst = 1'b1;
    #1 chk("rst_immediate", 32'(outs()), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_held", 32'(outs()), 0);
    end
    bus.btn_i = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    repeat (3) tick;
    chk("rst_after", 32'(outs()), 0);
    p0 = press_cnt;
    bus.btn_i = 1'b1;
    repeat (3) tick;
    bus.btn_i = 1'b0;
    tick;
    bus.btn_i = 1'b1;
    repeat (5) tick;
    chk("bounce_none", press_cnt - p0, 0);
    chk("bounce_pre", 32'(outs()), 0);
    tick;
    chk("bounce_accept", 32'(outs()), 3'b111);
    repeat (10) tick;
    chk("bounce_one_pulse", press_cnt - p0, 1);
    p0 = press_cnt;
    bus.btn_i = 1'b0;
    repeat (2) tick;
    bus.btn_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("glitch_stable", 32'(bus.stable_o), 1);
    end
    bus.btn_i = 1'b0;
    repeat (5) tick;
    chk("release_pre", 32'(outs()), 3'b110);
    tick;
    chk("release_fall", 32'(outs()), 3'b100);
    repeat (5) tick;
    chk("release_no_pulse", press_cnt - p0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    p0 = press_cnt;
    bus.btn_i = 1'b1;
    repeat (10) tick;
    chk("two_sel_1", 32'(bus.sel_o), 1);
    bus.btn_i = 1'b0;
    repeat (10) tick;
    chk("two_rel_1", 32'(outs()), 3'b100);
    bus.btn_i = 1'b1;
    repeat (10) tick;
    chk("two_sel_2", 32'(outs()), 3'b010);
    bus.btn_i = 1'b0;
    repeat (10) tick;
    chk("two_rel_2", 32'(outs()), 0);
    chk("two_pulses", press_cnt - p0, 2);
    bus.btn_i = 1'b1;
    repeat (4) tick;
    rst = 1'b1;
    #1 chk("midchk_rst_imm", 32'(outs()), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("midchk_rst_held", 32'(outs()), 0);
    end
    rst = 1'b0;
    p0 = press_cnt;
    repeat (5) tick;
    chk("midchk_pre", 32'(outs()), 0);
    tick;
    chk("midchk_accept", 32'(outs()), 3'b111);
    repeat (10) tick;
    chk("midchk_one_pulse", press_cnt - p0, 1);
    chk("no_double_pulse", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sel_debounce.md
# sel_debounce

Debounces and synchronizes a raw pushbutton and produces the select line for the 2:1 lab mux. Each clean press toggles `sel_o`, which connects directly to the mux `sel_i`. The block also exports the debounced button level and a one-cycle press pulse. It sits between the board pushbutton pin and the mux.

## Interface
- `DEBOUNCE_CYCLES`, default 500000, is the number of consecutive synchronized samples that must agree before a level change is accepted. At 100 MHz the default is 5 ms. The legal range is >= 1.
- `clk_i`  input  1  system clock. All state updates on the rising edge.
- `rst_i`  input  1  reset. One clock; reset is asynchronous and active-high.
- `btn_i`  input  1  raw, asynchronous, bouncing pushbutton (1 = pressed).
- `sel_o`  output  1  mux select. Toggles once per accepted press.
- `stable_o`  output  1  debounced button level.
- `press_o`  output  1  one-cycle pulse on each accepted press.

## Operation
- **Synchronizer.** A 2-flop synchronizer `btn_i -> s1 -> btn_s`. Only `btn_s` is used by the logic.
- **Counter.** `cnt` has width $clog2(DEBOUNCE_CYCLES+1) and is unsigned. It never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- **FSM states.** RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE. The FSM samples `btn_s` once per edge.
- **RELEASED:**
  - `btn_s`=0: stay.
  - `btn_s`=1 and DEBOUNCE_CYCLES=1: go to PRESSED with accept actions.
  - `btn_s`=1 otherwise: go to CHECK_PRESS with `cnt`=1.
- **CHECK_PRESS:**
  - `btn_s`=0: go to RELEASED, `cnt`=0. This is a bounce; nothing is emitted.
  - `btn_s`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to PRESSED with accept actions, `cnt`=0.
  - `btn_s`=1 otherwise: `cnt`++.
- **PRESSED:** the mirror of RELEASED, with `btn_s`=0 as the trigger, going to CHECK_RELEASE or directly to RELEASED.
- **CHECK_RELEASE:**
  - `btn_s`=1: go to PRESSED, `cnt`=0. No pulse is emitted.
  - `btn_s`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to RELEASED, `cnt`=0.
  - `btn_s`=0 otherwise: `cnt`++.
- **Accept actions (press only), at the same edge:**
  - `sel_o` <= ~`sel_o`
  - `press_o` <= 1
  - `stable_o` <= 1
- **Release acceptance.** `stable_o` <= 0. `sel_o` is unchanged and no pulse is emitted.
- **Register defaults.** `press_o` is registered and is 0 on every edge without a press acceptance. `stable_o` is a registered output: 1 in PRESSED and CHECK_RELEASE, 0 otherwise.

## Timing
- **Reset values** (asynchronous, immediate on `rst_i`=1):
  - `sel_o`=0, `stable_o`=0, `press_o`=0
  - `s1`=0, `btn_s`=0
  - `cnt`=0, state = RELEASED
- **Press latency.** Let E0 be the first edge at which `s1` captures `btn_i`=1, with `btn_i` held thereafter. Then `sel_o`, `stable_o` and `press_o` update at edge E0+DEBOUNCE_CYCLES+1. `press_o` returns to 0 at the next edge.
- **Release latency.** Symmetric: `stable_o` falls at E1+DEBOUNCE_CYCLES+1, where E1 is the first edge `s1` captures 0.
- **Bounce.** Any opposite sample during a CHECK state restarts qualification from the stable state. A press is counted only after DEBOUNCE_CYCLES uninterrupted samples.
- **Press rate.**
  - At most one `press_o` pulse per PRESSED entry from RELEASED/CHECK_PRESS.
  - Returning to PRESSED from CHECK_RELEASE emits no pulse.
  - `press_o` is never high on two consecutive cycles.
- **Reset mid-operation.** Any state or count is discarded. If the button is held through reset deassertion, it is re-qualified from scratch: the first `s1` capture after deassertion is E0, and one press is then generated.
- **Metastability.** `btn_i` may change arbitrarily relative to `clk_i`. No logic other than `s1` observes it.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a 10 ns clock.

1. **Reset.** Assert `rst_i` mid-cycle with `btn_i`=1 for 3 cycles. Required: all outputs 0 immediately (before the next edge) and for every cycle while reset is held.
2. **Clean press.** `btn_i` goes 0->1 before edge E0 and is held. Required: at E0+5, `sel_o` 0->1, `stable_o`=1 and `press_o`=1; at E0+6, `press_o`=0. No other pulse occurs in 20 further cycles.
3. **Bounce on press.**
   - Stimulus: `btn_i` 1 for 3 cycles, 0 for 1 cycle, then 1 held from edge E.
   - Required: nothing during the bounce; exactly one `press_o`, at E+5; `sel_o`=1.
4. **Release glitch, then full release.**
   - Stimulus: from PRESSED, `btn_i` 0 for 2 cycles then 1. Then full release starting at edge E1.
   - Required for the glitch: `stable_o` stays 1 and there is no pulse.
   - Required for the full release: `stable_o` falls at E1+5; `sel_o` is unchanged; `press_o` stays 0.
5. **Two presses.** Two full press/release sequences, each with 10-cycle holds. Required: `sel_o` 0->1->0 and exactly two single-cycle `press_o` pulses.
6. **Reset during CHECK_PRESS.**
   - Stimulus: `btn_i` held 1; assert `rst_i` when `cnt`=2, then deassert with the button still held.
   - Required: outputs stay 0 through reset. Exactly one press follows, 5 edges after the first post-reset `s1` capture, with `sel_o`=1.
